// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state encodings,
// error codes and the default frame sync value.
package uart_pkg;

    typedef enum logic [2:0] {
        s_IDLE    = 3'd0,
        s_LEN     = 3'd1,
        s_PAYLOAD = 3'd2,
        s_CKSUM   = 3'd3,
        s_DRAIN   = 3'd4
    } frame_state_t;

    localparam logic [1:0] ERR_LEN     = 2'd1;
    localparam logic [1:0] ERR_CKSUM   = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload store for one frame: single write port, asynchronous read port.
// Contents are only meaningful after a frame has been written, so no reset.
module uart_frame_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_frame_parser.sv
// Frame parser behind the UART receiver: SYNC, LEN, payload, CKSUM; good
// payloads are replayed over valid/ready, bad frames are reported and dropped.
//
// state     | meaning
// s_IDLE    | hunting for the sync byte
// s_LEN     | waiting for the length byte
// s_PAYLOAD | storing payload bytes, accumulating sum
// s_CKSUM   | waiting for the checksum byte
// s_DRAIN   | replaying the buffered payload to the consumer
module uart_frame_parser
    import uart_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE    = SYNC_DEFAULT,
    parameter int         MAX_LEN      = 16,
    parameter int         TIMEOUT_CLKS = 2000
) (
    input  logic       i_Clock,
    input  logic       i_Reset,
    input  logic       i_Rx_DV,
    input  logic [7:0] i_Rx_Byte,
    output logic       o_Data_Valid,
    output logic [7:0] o_Data_Byte,
    input  logic       i_Data_Ready,
    output logic       o_Frame_Last,
    output logic [7:0] o_Frame_Len,
    output logic       o_Err,
    output logic [1:0] o_Err_Code,
    output logic       o_Overrun,
    output logic       o_Busy
);

    localparam int IW = $clog2(MAX_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CLKS);
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    frame_state_t  state_q, state_d;
    logic [IW-1:0] len_q, len_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d;
    logic [IW-1:0] rd_idx_q, rd_idx_d;
    logic [7:0]    sum_q, sum_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic          err_q, err_d;
    logic [1:0]    code_q, code_d;
    logic          ovr_q, ovr_d;

    logic          wr_en;
    logic [7:0]    rd_data;
    logic          timed_q;
    logic          expired;
    logic          len_bad;
    logic          draining;
    logic          last_rd;

    uart_frame_buf #(
        .DEPTH (MAX_LEN),
        .AW    (AW)
    ) u_buf (
        .clk     (i_Clock),
        .wr_en   (wr_en),
        .wr_addr (wr_idx_q[AW-1:0]),
        .wr_data (i_Rx_Byte),
        .rd_addr (rd_idx_q[AW-1:0]),
        .rd_data (rd_data)
    );

    assign timed_q  = state_q inside {s_LEN, s_PAYLOAD, s_CKSUM};
    assign expired  = (tmr_q == TW'(TIMEOUT_CLKS - 1));
    assign len_bad  = (i_Rx_Byte == 8'd0) || (i_Rx_Byte > 8'(MAX_LEN));
    assign draining = (state_q == s_DRAIN);
    assign last_rd  = (rd_idx_q == len_q - IW'(1));

    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state_q  <= s_IDLE;
            len_q    <= '0;
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            sum_q    <= '0;
            tmr_q    <= '0;
            err_q    <= 1'b0;
            code_q   <= 2'd0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            len_q    <= len_d;
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            sum_q    <= sum_d;
            tmr_q    <= tmr_d;
            err_q    <= err_d;
            code_q   <= code_d;
            ovr_q    <= ovr_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        sum_d    = sum_q;
        err_d    = 1'b0;
        code_d   = code_q;
        ovr_d    = 1'b0;
        wr_en    = 1'b0;

        case (state_q)
            s_IDLE: begin
                if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
                    state_d = s_LEN;
                end
            end
            s_LEN: begin
                if (i_Rx_DV) begin
                    if (len_bad) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = s_IDLE;
                    end else begin
                        len_d    = IW'(i_Rx_Byte);
                        sum_d    = i_Rx_Byte;
                        wr_idx_d = '0;
                        state_d  = s_PAYLOAD;
                    end
                end
            end
            s_PAYLOAD: begin
                if (i_Rx_DV) begin
                    wr_en    = 1'b1;
                    sum_d    = sum_q + i_Rx_Byte;
                    wr_idx_d = wr_idx_q + IW'(1);
                    if (wr_idx_q == len_q - IW'(1)) begin
                        state_d = s_CKSUM;
                    end
                end
            end
            s_CKSUM: begin
                if (i_Rx_DV) begin
                    if (i_Rx_Byte == sum_q) begin
                        rd_idx_d = '0;
                        state_d  = s_DRAIN;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CKSUM;
                        state_d = s_IDLE;
                    end
                end
            end
            s_DRAIN: begin
                ovr_d = i_Rx_DV;
                if (i_Data_Ready) begin
                    rd_idx_d = rd_idx_q + IW'(1);
                    if (last_rd) begin
                        state_d = s_IDLE;
                    end
                end
            end
            default: state_d = s_IDLE;
        endcase

        // A byte arriving on the expiry cycle keeps the frame alive.
        if (timed_q && !i_Rx_DV && expired) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = s_IDLE;
        end

        tmr_d = (timed_q && (state_d == state_q) && !i_Rx_DV) ? tmr_q + TW'(1) : '0;
    end

    assign o_Data_Valid = draining;
    assign o_Data_Byte  = draining ? rd_data : 8'h00;
    assign o_Frame_Last = draining && last_rd;
    assign o_Frame_Len  = draining ? 8'(len_q) : 8'h00;
    assign o_Err        = err_q;
    assign o_Err_Code   = code_q;
    assign o_Overrun    = ovr_q;
    assign o_Busy       = (state_q != s_IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scoreboard bench for uart_frame_parser: directed frames plus randomized
// frames whose expected outcome is computed from the frame rules.
module tb_uart_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TC      = 64;

    logic       i_Clock = 1'b0;
    logic       i_Reset = 1'b1;
    logic       i_Rx_DV = 1'b0;
    logic [7:0] i_Rx_Byte = 8'h00;
    logic       i_Data_Ready = 1'b1;
    logic       o_Data_Valid;
    logic [7:0] o_Data_Byte;
    logic       o_Frame_Last;
    logic [7:0] o_Frame_Len;
    logic       o_Err;
    logic [1:0] o_Err_Code;
    logic       o_Overrun;
    logic       o_Busy;

    uart_frame_parser #(
        .SYNC_BYTE    (8'hA5),
        .MAX_LEN      (MAX_LEN),
        .TIMEOUT_CLKS (TC)
    ) dut (
        .i_Clock      (i_Clock),
        .i_Reset      (i_Reset),
        .i_Rx_DV      (i_Rx_DV),
        .i_Rx_Byte    (i_Rx_Byte),
        .o_Data_Valid (o_Data_Valid),
        .o_Data_Byte  (o_Data_Byte),
        .i_Data_Ready (i_Data_Ready),
        .o_Frame_Last (o_Frame_Last),
        .o_Frame_Len  (o_Frame_Len),
        .o_Err        (o_Err),
        .o_Err_Code   (o_Err_Code),
        .o_Overrun    (o_Overrun),
        .o_Busy       (o_Busy)
    );

    always #5 i_Clock = ~i_Clock;

    typedef struct {
        logic [7:0] b;
        logic       last;
        logic [7:0] len;
    } dexp_t;

    dexp_t      dq[$];
    logic [1:0] eq[$];
    logic [7:0] fr[$];
    int total = 0;
    int bad = 0;
    int ovr_exp = 0;
    int ovr_seen = 0;
    bit rnd_ready = 1'b0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents a result.
    dexp_t d;
    logic [1:0] e;
    always @(negedge i_Clock) begin
        if (!i_Reset) begin
            if (o_Data_Valid && i_Data_Ready) begin
                if (dq.size() == 0) begin
                    chk("unexpected_data", 1, 0);
                end else begin
                    d = dq.pop_front();
                    chk("data_byte", o_Data_Byte, d.b);
                    chk("data_last", o_Frame_Last, d.last);
                    chk("data_len", o_Frame_Len, d.len);
                end
            end
            if (o_Err) begin
                if (eq.size() == 0) begin
                    chk("unexpected_err", 1, 0);
                end else begin
                    e = eq.pop_front();
                    chk("err_code", o_Err_Code, e);
                end
            end
            if (o_Overrun) ovr_seen++;
        end
    end

    // Driver helpers: called at #1 after a rising edge; each byte is one strobe cycle.
    task automatic send_byte(input logic [7:0] b);
        i_Rx_Byte = b;
        i_Rx_DV   = 1'b1;
        @(posedge i_Clock);
        #1;
        i_Rx_DV   = 1'b0;
        i_Rx_Byte = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge i_Clock);
        #1;
    endtask

    task automatic send_fr(input int maxgap);
        foreach (fr[i]) begin
            if (i != 0 && maxgap > 0) idle($urandom_range(0, maxgap));
            send_byte(fr[i]);
        end
        fr.delete();
    endtask

    task automatic wait_idle(input int limit);
        int cnt = 0;
        while (o_Busy && cnt < limit) begin
            if (rnd_ready) i_Data_Ready = 1'($urandom_range(0, 1));
            @(posedge i_Clock);
            #1;
            cnt++;
        end
        i_Data_Ready = 1'b1;
        chk("returned_idle", o_Busy, 0);
    endtask

    // Reference: a good frame yields its payload in order, last flag on final byte.
    task automatic build_good(input int len, input bit push);
        int s = len;
        logic [7:0] p;
        fr.push_back(8'hA5);
        fr.push_back(8'(len));
        for (int i = 0; i < len; i++) begin
            p = 8'($urandom);
            s += p;
            fr.push_back(p);
            if (push) dq.push_back('{b: p, last: (i == len - 1), len: 8'(len)});
        end
        fr.push_back(8'(s % 256));
    endtask

    task automatic push_list(input logic [7:0] a[$]);
        foreach (a[i]) fr.push_back(a[i]);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int kind;
        int len;
        int s;
        logic [7:0] g;
        logic [7:0] p;

        repeat (3) @(posedge i_Clock);
        #1;
        chk("rst_valid", o_Data_Valid, 0);
        chk("rst_busy", o_Busy, 0);
        chk("rst_err", o_Err, 0);
        chk("rst_code", o_Err_Code, 0);
        chk("rst_byte", o_Data_Byte, 0);
        chk("rst_len", o_Frame_Len, 0);
        i_Reset = 1'b0;
        idle(2);

        // Good frame with exact drain timing.
        dq.push_back('{b: 8'h11, last: 1'b0, len: 8'd3});
        dq.push_back('{b: 8'h22, last: 1'b0, len: 8'd3});
        dq.push_back('{b: 8'h33, last: 1'b1, len: 8'd3});
        push_list('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69});
        send_fr(0);
        chk("good_valid0", o_Data_Valid, 1);
        chk("good_byte0", o_Data_Byte, 8'h11);
        chk("good_last0", o_Frame_Last, 0);
        chk("good_len", o_Frame_Len, 3);
        idle(1);
        chk("good_byte1", o_Data_Byte, 8'h22);
        chk("good_last1", o_Frame_Last, 0);
        idle(1);
        chk("good_byte2", o_Data_Byte, 8'h33);
        chk("good_last2", o_Frame_Last, 1);
        idle(1);
        chk("good_valid_fall", o_Data_Valid, 0);
        chk("good_busy_fall", o_Busy, 0);

        // Checksum error.
        eq.push_back(2'd2);
        push_list('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A});
        send_fr(0);
        chk("cks_err_pulse", o_Err, 1);
        chk("cks_err_code", o_Err_Code, 2);
        chk("cks_no_valid", o_Data_Valid, 0);
        chk("cks_idle", o_Busy, 0);
        idle(1);
        chk("cks_err_one_cycle", o_Err, 0);
        chk("cks_code_held", o_Err_Code, 2);

        // Length checks.
        eq.push_back(2'd1);
        send_byte(8'hA5);
        send_byte(8'h00);
        chk("len0_err", o_Err, 1);
        chk("len0_code", o_Err_Code, 1);
        idle(1);
        eq.push_back(2'd1);
        send_byte(8'hA5);
        send_byte(8'h11);
        chk("len17_err", o_Err, 1);
        chk("len17_code", o_Err_Code, 1);
        idle(1);

        // Leading garbage then a good frame.
        push_list('{8'h00, 8'hFF});
        build_good(4, 1'b1);
        send_fr(0);
        wait_idle(50);

        // Timeout: error exactly TC cycles after the last strobe.
        eq.push_back(2'd3);
        push_list('{8'hA5, 8'h02, 8'h11});
        send_fr(0);
        cnt = 0;
        while (!o_Err && cnt < TC + 5) begin
            @(posedge i_Clock);
            #1;
            cnt++;
        end
        chk("timeout_latency", cnt, TC);
        chk("timeout_code", o_Err_Code, 3);
        chk("timeout_idle", o_Busy, 0);
        idle(1);

        // Byte landing on the expiry cycle keeps the frame alive.
        dq.push_back('{b: 8'h11, last: 1'b0, len: 8'd2});
        dq.push_back('{b: 8'h22, last: 1'b1, len: 8'd2});
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'h11);
        idle(TC - 1);
        send_byte(8'h22);
        chk("expiry_byte_no_err", o_Err, 0);
        chk("expiry_byte_busy", o_Busy, 1);
        send_byte(8'h35);
        wait_idle(20);

        // Backpressure with an overrun strobe mid-drain.
        i_Data_Ready = 1'b0;
        dq.push_back('{b: 8'h10, last: 1'b0, len: 8'd2});
        dq.push_back('{b: 8'h20, last: 1'b1, len: 8'd2});
        push_list('{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32});
        send_fr(0);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", o_Data_Valid, 1);
            chk("bp_byte_stable", o_Data_Byte, 8'h10);
            chk("bp_len_stable", o_Frame_Len, 2);
            chk("bp_last_stable", o_Frame_Last, 0);
            if (i == 2) begin
                send_byte(8'h77);
                ovr_exp++;
                chk("ovr_pulse", o_Overrun, 1);
            end else begin
                idle(1);
                chk("ovr_quiet", o_Overrun, 0);
            end
        end
        i_Data_Ready = 1'b1;
        wait_idle(20);

        // Reset during payload, then a good frame containing the sync value.
        send_byte(8'hA5);
        send_byte(8'h04);
        send_byte(8'h01);
        send_byte(8'h02);
        i_Reset = 1'b1;
        #1;
        chk("rstp_busy", o_Busy, 0);
        chk("rstp_code", o_Err_Code, 0);
        chk("rstp_valid", o_Data_Valid, 0);
        @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        idle(1);
        dq.push_back('{b: 8'hA5, last: 1'b0, len: 8'd2});
        dq.push_back('{b: 8'h5A, last: 1'b1, len: 8'd2});
        push_list('{8'hA5, 8'h02, 8'hA5, 8'h5A, 8'h01});
        send_fr(0);
        wait_idle(20);

        // Reset mid-drain drops valid asynchronously.
        i_Data_Ready = 1'b0;
        push_list('{8'hA5, 8'h01, 8'h42, 8'h43});
        send_fr(0);
        chk("rstd_valid_before", o_Data_Valid, 1);
        i_Reset = 1'b1;
        #1;
        chk("rstd_valid_async", o_Data_Valid, 0);
        chk("rstd_byte", o_Data_Byte, 0);
        @(posedge i_Clock);
        #1;
        i_Reset = 1'b0;
        i_Data_Ready = 1'b1;
        idle(2);
        chk("rstd_stays_idle", o_Busy, 0);

        // Randomized frames.
        rnd_ready = 1'b1;
        for (int f = 0; f < 40; f++) begin
            kind = $urandom_range(0, 9);
            for (int k = $urandom_range(0, 2); k > 0; k--) begin
                do g = 8'($urandom); while (g == 8'hA5);
                fr.push_back(g);
            end
            if (kind == 0) begin
                len = ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(MAX_LEN + 1, 255);
                fr.push_back(8'hA5);
                fr.push_back(8'(len));
                eq.push_back(2'd1);
            end else if (kind == 1) begin
                len = $urandom_range(1, MAX_LEN);
                s = len;
                fr.push_back(8'hA5);
                fr.push_back(8'(len));
                for (int i = 0; i < len; i++) begin
                    p = 8'($urandom);
                    s += p;
                    fr.push_back(p);
                end
                fr.push_back(8'((s + $urandom_range(1, 255)) % 256));
                eq.push_back(2'd2);
            end else begin
                build_good($urandom_range(1, MAX_LEN), 1'b1);
            end
            send_fr(3);
            wait_idle(400);
            idle($urandom_range(0, 2));
        end
        rnd_ready = 1'b0;

        idle(5);
        chk("data_queue_empty", dq.size(), 0);
        chk("err_queue_empty", eq.size(), 0);
        chk("overrun_count", ovr_seen, ovr_exp);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
